// File: rtl/sonos_pkg.sv
// Shared types and defaults for the I2S receive path.
// Imported by the sample receiver.
package sonos_pkg;

    typedef enum logic [1:0] {
        HUNT,
        RX_L,
        RX_R
    } i2s_state_e;

    localparam int SAMPLE_W_DEF = 16;
    localparam int SLOT_MAX_DEF = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs.
// Width-parameterised, clears to zero on reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // two-stage metastability filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2s_sample_rx.sv
// Philips I2S stereo receiver with BCLK oversampled in the clk domain.
// Presents one left/right pair per frame on a valid/ready output.
module i2s_sample_rx
    import sonos_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int SLOT_MAX = SLOT_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                i2s_bclk,
    input  logic                i2s_lrck,
    input  logic                i2s_sd,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    output logic                frame_err,
    input  logic                status_clr
);

    localparam int CNT_W = $clog2(SLOT_MAX + 1);
    localparam logic [CNT_W-1:0] W_C    = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(SLOT_MAX);
    localparam logic [CNT_W-1:0] MAXM1  = CNT_W'(SLOT_MAX - 1);

    logic [2:0]          pins_s;
    logic                bclk_s;
    logic                lrck_s;
    logic                sd_s;
    logic                bclk_prev;
    logic                lrck_last;
    logic                rise;
    logic                lrck_chg;

    i2s_state_e          state_q;
    i2s_state_e          state_d;
    logic                latch_left;
    logic                frame_done;
    logic                slot_ovf;

    logic [SAMPLE_W-1:0] shreg;
    logic [SAMPLE_W-1:0] shreg_app;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] left_hold;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    n_taken;
    logic [CNT_W-1:0]    shamt;
    logic                take;

    sync_2ff #(
        .W (3)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({i2s_bclk, i2s_lrck, i2s_sd}),
        .q     (pins_s)
    );

    assign bclk_s   = pins_s[2];
    assign lrck_s   = pins_s[1];
    assign sd_s     = pins_s[0];
    assign rise     = bclk_s & ~bclk_prev;
    assign lrck_chg = lrck_s != lrck_last;

    // append the current bit and left-justify the taken bits
    always_comb begin
        take      = cnt < W_C;
        shreg_app = shreg;
        n_taken   = W_C;
        if (take) begin
            shreg_app = {shreg[SAMPLE_W-2:0], sd_s};
            n_taken   = cnt + 1'b1;
        end
        shamt = W_C - n_taken;
        word  = shreg_app << shamt;
    end

    // frame-tracking next state and slot events
    always_comb begin
        state_d    = state_q;
        latch_left = 1'b0;
        frame_done = 1'b0;
        slot_ovf   = 1'b0;
        if (!ena) begin
            state_d = HUNT;
        end else if (rise) begin
            unique case (state_q)
                HUNT: begin
                    if (lrck_chg && !lrck_s) begin
                        state_d = RX_L;
                    end
                end
                RX_L: begin
                    if (lrck_chg && lrck_s) begin
                        latch_left = 1'b1;
                        state_d    = RX_R;
                    end else if (!lrck_chg && cnt == MAXM1) begin
                        slot_ovf = 1'b1;
                        state_d  = HUNT;
                    end
                end
                RX_R: begin
                    if (lrck_chg && !lrck_s) begin
                        frame_done = 1'b1;
                        state_d    = RX_L;
                    end else if (!lrck_chg && cnt == MAXM1) begin
                        slot_ovf = 1'b1;
                        state_d  = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // edge history, shift register and slot bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_prev <= 1'b0;
            lrck_last <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            left_hold <= '0;
        end else begin
            bclk_prev <= bclk_s;
            if (rise) begin
                lrck_last <= lrck_s;
                if (lrck_chg) begin
                    shreg <= '0;
                    cnt   <= '0;
                end else begin
                    shreg <= shreg_app;
                    if (cnt != MAX_C) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
            if (latch_left) begin
                left_hold <= word;
            end
        end
    end

    // output pair register with valid/ready handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
        end else if (!ena) begin
            sample_valid <= 1'b0;
        end else if (frame_done && (!sample_valid || sample_ready)) begin
            sample_l     <= left_hold;
            sample_r     <= word;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // sticky status flags; a new event beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (frame_done && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (status_clr) begin
                overrun <= 1'b0;
            end
            if (slot_ovf) begin
                frame_err <= 1'b1;
            end else if (status_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule
